// File: rtl/lpif_quarter_pack_ctrl.sv
// ---------------------------------------------------------------------------
// lpif_quarter_pack_ctrl
//
// Packs upstream LPIF flit beats into wide words for a TX FIFO. Up to NSLOT
// beats are collected in an accumulator and then moved into a single output
// holding register. The word length is NSLOT beats, or 2 beats in gen2
// (half-rate) mode. A partial word can be emitted with flush_req.
//
// Optional feature (macro LPIF_QPACK_TIMEOUT_EN): an idle counter flushes a
// partial word automatically after TMO_CYC cycles without a new beat.
//
// Ports:
//   clk_wr       single clock
//   rst_wr_n     asynchronous active-low reset (deasserted synchronously
//                outside this block)
//   in_flit      upstream beat, FLIT_W bits
//   in_vld       beat valid
//   in_rdy       beat accepted when in_vld && in_rdy
//   out_data     packed word, slot k at [k*FLIT_W +: FLIT_W]
//   out_vld      packed word valid
//   out_rdy      TX FIFO accepts when out_vld && out_rdy
//   m_gen2_mode  1 = half-rate packing (2 slots), sampled while empty
//   flush_req    single-cycle pulse, emit the partial word
//   flush_done   single-cycle pulse, flushed word moved to the output
//   slot_cnt     beats currently held in the accumulator
//   word_cnt     words moved to the output register (wraps)
// ---------------------------------------------------------------------------
module lpif_quarter_pack_ctrl #(
  parameter int FLIT_W  = 281,
  parameter int NSLOT   = 4,
  parameter int TMO_CYC = 16
) (
  input  logic                      clk_wr,
  input  logic                      rst_wr_n,
  input  logic [FLIT_W-1:0]         in_flit,
  input  logic                      in_vld,
  output logic                      in_rdy,
  output logic [FLIT_W*NSLOT-1:0]   out_data,
  output logic                      out_vld,
  input  logic                      out_rdy,
  input  logic                      m_gen2_mode,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic [2:0]                slot_cnt,
  output logic [15:0]               word_cnt
);

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [2:0] LEN_FULL = 3'(NSLOT);
  localparam logic [2:0] LEN_GEN2 = 3'd2;

  state_e                       state_q, state_d;
  logic [2:0]                   cnt_q, cnt_d;
  logic [2:0]                   len_q, len_d;
  logic [NSLOT-1:0][FLIT_W-1:0] acc_q, acc_d;
  logic [NSLOT-1:0][FLIT_W-1:0] hold_q, hold_d;
  logic                         out_vld_q, out_vld_d;
  logic                         done_q, done_d;
  logic [15:0]                  word_cnt_q, word_cnt_d;

  logic xfer_ok;
  logic in_rdy_c;
  logic accept;
  logic load_full;
  logic load;
  logic tmo_fire;

  // The holding register can take a new word when it is empty or draining.
  assign xfer_ok   = ~out_vld_q | out_rdy;
  // A full accumulator still accepts a beat if it can move out this cycle.
  assign in_rdy_c  = (state_q == FILL) && ((cnt_q < len_q) || xfer_ok);
  assign accept    = in_vld && in_rdy_c;
  assign load_full = (state_q == FILL) && (cnt_q == len_q) && xfer_ok;

`ifdef LPIF_QPACK_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);

  logic [TW-1:0] idle_q, idle_d;

  // Counts idle cycles while a partial word waits; fires on the cycle the
  // count reaches TMO_CYC, which then acts exactly like a flush_req.
  always_comb begin
    idle_d   = '0;
    tmo_fire = 1'b0;
    if ((state_q == FILL) && (cnt_q != 3'd0) && !accept) begin
      idle_d   = idle_q + TW'(1);
      tmo_fire = (idle_d == TW'(TMO_CYC));
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) idle_q <= '0;
    else           idle_q <= idle_d;
  end
`else
  // No idle timer in this build; the comparison is constant false.
  assign tmo_fire = (TMO_CYC < 0);
`endif

  // NOTE: every combinational output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    acc_d      = acc_q;
    hold_d     = hold_q;
    out_vld_d  = out_vld_q;
    done_d     = 1'b0;
    word_cnt_d = word_cnt_q;
    load       = 1'b0;

    // Word length only follows the mode pin while the accumulator is empty.
    if (cnt_q == 3'd0) len_d = m_gen2_mode ? LEN_GEN2 : LEN_FULL;

    if (out_vld_q && out_rdy) out_vld_d = 1'b0;

    case (state_q)
      FILL: begin
        if (load_full) begin
          load  = 1'b1;
          cnt_d = 3'd0;
          acc_d = '0;
        end
        if (accept) begin
          // A beat arriving with the move starts the next word in slot 0.
          for (int k = 0; k < NSLOT; k++) begin
            if (3'(k) == (load_full ? 3'd0 : cnt_q)) acc_d[k] = in_flit;
          end
          cnt_d = load_full ? 3'd1 : cnt_q + 3'd1;
        end
        // A request on the beat that completes the word is just a full word.
        if ((flush_req || tmo_fire) && (cnt_q != 3'd0) && !load_full &&
            (cnt_d < len_q)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (xfer_ok) begin
          load    = 1'b1;
          cnt_d   = 3'd0;
          acc_d   = '0;
          done_d  = 1'b1;
          state_d = FILL;
        end
      end
    endcase

    if (load) begin
      // Slots at or above the fill level go out as zero.
      for (int k = 0; k < NSLOT; k++) begin
        hold_d[k] = (3'(k) < cnt_q) ? acc_q[k] : '0;
      end
      out_vld_d  = 1'b1;
      word_cnt_d = word_cnt_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  // NOTE: the accumulator and holding register are reset too, because a
  // reset must discard any partial or held word rather than leave stale data.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q    <= FILL;
      cnt_q      <= 3'd0;
      len_q      <= LEN_FULL;
      acc_q      <= '0;
      hold_q     <= '0;
      out_vld_q  <= 1'b0;
      done_q     <= 1'b0;
      word_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      hold_q     <= hold_d;
      out_vld_q  <= out_vld_d;
      done_q     <= done_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign in_rdy     = in_rdy_c;
  assign out_data   = hold_q;
  assign out_vld    = out_vld_q;
  assign flush_done = done_q;
  assign slot_cnt   = cnt_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_lpif_quarter_pack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lpif_quarter_pack_ctrl
//
// Directed stimulus with a scoreboard: the stimulus pushes each expected
// packed word (and whether it must carry flush_done) into a queue; a monitor
// pops and compares every time a new word appears on the output, and checks
// that a stalled word stays stable.
// ---------------------------------------------------------------------------
module tb_lpif_quarter_pack_ctrl;

  localparam int W   = 281;
  localparam int N   = 4;
  localparam int TMO = 16;

  typedef struct {
    logic [N-1:0][W-1:0] data;
    logic                flush;
  } exp_t;

  logic              clk_wr = 1'b0;
  logic              rst_wr_n;
  logic [W-1:0]      in_flit;
  logic              in_vld;
  logic              in_rdy;
  logic [W*N-1:0]    out_data;
  logic              out_vld;
  logic              out_rdy;
  logic              m_gen2_mode;
  logic              flush_req;
  logic              flush_done;
  logic [2:0]        slot_cnt;
  logic [15:0]       word_cnt;

  exp_t              exp_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                exp_wc  = 0;

  lpif_quarter_pack_ctrl #(.FLIT_W(W), .NSLOT(N), .TMO_CYC(TMO)) dut (
    .clk_wr      (clk_wr),
    .rst_wr_n    (rst_wr_n),
    .in_flit     (in_flit),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .m_gen2_mode (m_gen2_mode),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .slot_cnt    (slot_cnt),
    .word_cnt    (word_cnt)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Distinct, position-sensitive beat pattern derived from an 8-bit tag.
  function automatic logic [W-1:0] mk(input logic [7:0] tag);
    logic [W-1:0] f;
    f = '0;
    f[7:0]      = tag;
    f[15:8]     = ~tag;
    f[140 +: 8] = tag ^ 8'h5a;
    f[W-1 -: 8] = tag;
    return f;
  endfunction

  task automatic push(input logic [W-1:0] s0, input logic [W-1:0] s1,
                      input logic [W-1:0] s2, input logic [W-1:0] s3,
                      input logic fl);
    exp_t e;
    e.data[0] = s0;
    e.data[1] = s1;
    e.data[2] = s2;
    e.data[3] = s3;
    e.flush   = fl;
    exp_q.push_back(e);
    exp_wc++;
  endtask

  task automatic tick();
    @(posedge clk_wr);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic           prev_vld = 1'b0;
  logic           prev_hs  = 1'b0;
  logic [W*N-1:0] held     = '0;

  always @(negedge clk_wr) begin
    exp_t e;
    if (!rst_wr_n) begin
      prev_vld = 1'b0;
      prev_hs  = 1'b0;
    end else begin
      if (out_vld && !(prev_vld && !prev_hs)) begin
        check("word_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          for (int k = 0; k < N; k++)
            check($sformatf("word%0d_slot%0d", exp_wc - exp_q.size(), k),
                  out_data[k*W +: W], e.data[k]);
          check("word_flush_done", flush_done, e.flush);
        end
      end else begin
        if (flush_done) check("flush_done_without_word", flush_done, 0);
        if (out_vld) check("hold_stable", (out_data == held), 1);
      end
      held     = out_data;
      prev_vld = out_vld;
      prev_hs  = out_vld && out_rdy;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int  n;
    logic seen;
    rst_wr_n    = 1'b1;
    in_flit     = '0;
    in_vld      = 1'b0;
    out_rdy     = 1'b1;
    m_gen2_mode = 1'b0;
    flush_req   = 1'b0;
    #2 rst_wr_n = 1'b0;
    #1;
    check("rst_out_vld", out_vld, 0);
    check("rst_slot_cnt", slot_cnt, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_in_rdy", in_rdy, 1);
    tick();
    tick();
    rst_wr_n = 1'b1;

    // ---- full throughput: A0..A7 back to back ----
    for (int i = 0; i < 8; i++) begin
      in_flit = mk(8'hA0 + 8'(i));
      in_vld  = 1'b1;
      if (i == 3) push(mk(8'hA0), mk(8'hA1), mk(8'hA2), mk(8'hA3), 1'b0);
      if (i == 7) push(mk(8'hA4), mk(8'hA5), mk(8'hA6), mk(8'hA7), 1'b0);
      @(negedge clk_wr);
      check($sformatf("thr_in_rdy_%0d", i), in_rdy, 1);
      if (i == 4) check("thr_vld_before_w0", out_vld, 0);
      if (i == 5) check("thr_vld_w0", out_vld, 1);
      tick();
    end
    in_vld = 1'b0;
    @(negedge clk_wr);
    check("thr_vld_before_w1", out_vld, 0);
    tick();
    @(negedge clk_wr);
    check("thr_vld_w1", out_vld, 1);
    check("thr_word_cnt", word_cnt, 2);
    tick();
    tick();

    // ---- async reset with 2 beats held and a word waiting ----
    out_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_flit = mk(8'hD0 + 8'(i));
      in_vld  = 1'b1;
      if (i == 3) push(mk(8'hD0), mk(8'hD1), mk(8'hD2), mk(8'hD3), 1'b0);
      tick();
    end
    in_vld = 1'b0;
    @(negedge clk_wr);
    check("prerst_out_vld", out_vld, 1);
    check("prerst_slot_cnt", slot_cnt, 2);
    tick();
    rst_wr_n = 1'b0;
    exp_wc   = 0;
    #1;
    check("midrst_out_vld", out_vld, 0);
    check("midrst_slot_cnt", slot_cnt, 0);
    check("midrst_word_cnt", word_cnt, 0);
    tick();
    rst_wr_n = 1'b1;
    check("postrst_in_rdy", in_rdy, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_wr);
      check("postrst_no_word", out_vld, 0);
      tick();
    end

    // ---- gen2: two beats per word ----
    out_rdy     = 1'b1;
    m_gen2_mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_flit = mk(8'hB0 + 8'(i));
      in_vld  = 1'b1;
      if (i == 1) push(mk(8'hB0), mk(8'hB1), '0, '0, 1'b0);
      tick();
    end
    in_vld      = 1'b0;
    m_gen2_mode = 1'b0;
    @(negedge clk_wr);
    check("g2_vld_before", out_vld, 0);
    tick();
    @(negedge clk_wr);
    check("g2_vld", out_vld, 1);
    check("g2_word_cnt", word_cnt, 1);
    tick();

    // ---- backpressure: 9 beats offered with out_rdy low ----
    out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_flit = mk(8'hC0 + 8'(i));
      in_vld  = 1'b1;
      if (i == 3) push(mk(8'hC0), mk(8'hC1), mk(8'hC2), mk(8'hC3), 1'b0);
      if (i == 7) push(mk(8'hC4), mk(8'hC5), mk(8'hC6), mk(8'hC7), 1'b0);
      @(negedge clk_wr);
      check($sformatf("bp_in_rdy_%0d", i), in_rdy, 1);
      tick();
    end
    in_flit = mk(8'hC8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_wr);
      check("bp_in_rdy_stall", in_rdy, 0);
      check("bp_slot_cnt_full", slot_cnt, 4);
      tick();
    end
    out_rdy = 1'b1;
    @(negedge clk_wr);
    check("bp_in_rdy_release", in_rdy, 1);
    tick();
    out_rdy = 1'b0;
    in_vld  = 1'b0;
    @(negedge clk_wr);
    check("bp_slot_cnt_after", slot_cnt, 1);
    check("bp_out_vld_w1", out_vld, 1);
    tick();
    out_rdy = 1'b1;
    tick();
    flush_req = 1'b1;
    push(mk(8'hC8), '0, '0, '0, 1'b1);
    tick();
    flush_req = 1'b0;
    tick();
    tick();
    tick();

    // ---- flush of a 3-beat partial word ----
    for (int i = 0; i < 3; i++) begin
      in_flit = mk(8'hE0 + 8'(i));
      in_vld  = 1'b1;
      tick();
    end
    in_vld    = 1'b0;
    flush_req = 1'b1;
    push(mk(8'hE0), mk(8'hE1), mk(8'hE2), '0, 1'b1);
    tick();
    flush_req = 1'b0;
    @(negedge clk_wr);
    check("fl_in_rdy_flush", in_rdy, 0);
    tick();
    @(negedge clk_wr);
    check("fl_in_rdy_back", in_rdy, 1);
    check("fl_done", flush_done, 1);
    check("fl_slot_cnt", slot_cnt, 0);
    tick();
    @(negedge clk_wr);
    check("fl_done_pulse", flush_done, 0);
    tick();
    // flush with an empty accumulator does nothing
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_wr);
      check("fl_empty_no_word", out_vld, 0);
      tick();
    end
    check("fl_empty_word_cnt", word_cnt, 16'(exp_wc));

    // ---- idle timeout ----
    in_flit = mk(8'hF0);
    in_vld  = 1'b1;
`ifdef LPIF_QPACK_TIMEOUT_EN
    push(mk(8'hF0), '0, '0, '0, 1'b1);
`endif
    tick();
    in_vld = 1'b0;
    n      = 0;
    seen   = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_wr);
      if (out_vld && !seen) begin
        seen = 1'b1;
        n    = i;
      end
      tick();
    end
`ifdef LPIF_QPACK_TIMEOUT_EN
    check("tmo_word_seen", seen, 1);
    check("tmo_latency", n, TMO + 2);
    check("tmo_slot_cnt", slot_cnt, 0);
`else
    check("no_tmo_word", seen, 0);
    check("no_tmo_slot_cnt", slot_cnt, 1);
`endif

    check("final_word_cnt", word_cnt, 16'(exp_wc));
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
